irq_priority_encoder: RTL and testbench

Clocked 8-input priority encoder for interrupt and vector generation. It behaves as a registered 74LS148 with request latching and a CPU acknowledge handshake. Active-low request strobes, typically from decoder outputs elsewhere in the board logic, are synchronised, latched as pending, and encoded into an active-low 3-bit vector. A single active-low interrupt line goes to the CPU. The block sits between the address-decode and timing logic and the CPU interrupt input.

---
 rtl/irq_enc_pkg.sv | 26 ++
 rtl/irq_priority_encoder_sync_vec.sv | 32 +++
 rtl/irq_priority_encoder.sv | 128 ++++++++++++
 tb/tb_irq_priority_encoder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_enc_pkg.sv
// rtl/irq_enc_pkg.sv - shared types, constants and the 8:3 priority function for the interrupt encoder
package irq_enc_pkg;

    // Acknowledge handshake states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } irq_state_t;

    // Active-low vector value that means "nothing to report"
    localparam logic [2:0] IRQ_VEC_NONE = 3'b111;

    // Index of the highest set bit; bit 7 wins. Returns 0 for an all-zero input,
    // so callers must qualify the result with a separate "any set" test.
    function automatic logic [2:0] prio_enc8(input logic [7:0] p);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (p[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_priority_encoder_sync_vec.sv
// rtl/irq_priority_encoder_sync_vec.sv - clock-enabled multi-flop synchroniser for a vector of active-low inputs
module sync_vec #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             cen,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // One register per stage; stage 0 takes the asynchronous input.
    logic [WIDTH-1:0] stage [DEPTH];

    // Shift the inputs through the chain; resets to the inactive (all-ones) level.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int s = 0; s < DEPTH; s++) begin
                stage[s] <= '1;
            end
        end else if (cen) begin
            stage[0] <= d;
            for (int s = 1; s < DEPTH; s++) begin
                stage[s] <= stage[s-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/irq_priority_encoder.sv
// rtl/irq_priority_encoder.sv - registered 74LS148-style interrupt encoder with pending latches and CPU acknowledge
module irq_priority_encoder
    import irq_enc_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       cen,
    input  logic [7:0] n_req,
    input  logic       n_ei,
    input  logic       n_iack,
    output logic [2:0] a,
    output logic       n_gs,
    output logic       n_irq,
    output logic [7:0] pending
);

    logic [7:0] rs;
    logic [7:0] rs_prev;
    logic [7:0] fall;
    logic [7:0] ack_clr;
    logic [7:0] pending_next;
    logic [2:0] ack_idx;
    logic [2:0] enc_idx;
    logic       enc_gs;
    logic       take_ack;
    logic [2:0] held;
    irq_state_t state;

    sync_vec #(
        .WIDTH (8),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .n_reset (n_reset),
        .cen     (cen),
        .d       (n_req),
        .q       (rs)
    );

    // Previous synchronised request level, for falling-edge detection.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rs_prev <= '1;
        end else if (cen) begin
            rs_prev <= rs;
        end
    end

    assign fall = rs_prev & ~rs;

    // The CPU acknowledges whatever vector it currently sees on a, so the
    // index to clear comes from the registered output, not the live encoder.
    assign ack_idx  = ~a;
    assign take_ack = (state == IDLE) && !n_iack && !n_gs;

    // Decode the acknowledged index into a one-hot clear mask.
    always_comb begin
        ack_clr = '0;
        if (take_ack) begin
            ack_clr[ack_idx] = 1'b1;
        end
    end

    // Edge mode: a new falling edge overrides a same-cycle acknowledge clear.
    // Level mode: pending simply reflects the synchronised request.
    assign pending_next = EDGE_MODE ? ((pending & ~ack_clr) | fall) : ~rs;

    // Pending latches.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            pending <= '0;
        end else if (cen) begin
            pending <= pending_next;
        end
    end

    assign enc_idx = prio_enc8(pending);
    assign enc_gs  = (pending != 8'h00) && !n_ei;

    // Acknowledge FSM with registered vector, group-select and interrupt outputs.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
            held  <= 3'd0;
            a     <= IRQ_VEC_NONE;
            n_gs  <= 1'b1;
            n_irq <= 1'b1;
        end else if (cen) begin
            case (state)
                IDLE: begin
                    if (take_ack) begin
                        state <= ACK;
                        held  <= ack_idx;
                        n_irq <= 1'b1;
                    end else begin
                        a     <= enc_gs ? ~enc_idx : IRQ_VEC_NONE;
                        n_gs  <= ~enc_gs;
                        n_irq <= ~enc_gs;
                    end
                end
                ACK: begin
                    if (n_iack) begin
                        // Present nothing for one cycle so the CPU sees a clean
                        // re-assertion of whatever is still pending.
                        state <= IDLE;
                        a     <= IRQ_VEC_NONE;
                        n_gs  <= 1'b1;
                        n_irq <= 1'b1;
                    end else begin
                        a     <= ~held;
                        n_gs  <= 1'b0;
                        n_irq <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    a     <= IRQ_VEC_NONE;
                    n_gs  <= 1'b1;
                    n_irq <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_priority_encoder.sv
// tb/tb_irq_priority_encoder.sv - randomized and directed self-checking bench for irq_priority_encoder
module tb_irq_priority_encoder;

    localparam int SS = 2;

    logic       clk;
    logic       n_reset;
    logic       cen;
    logic [7:0] n_req;
    logic       n_ei;
    logic       n_iack;

    logic [2:0] a0, a1;
    logic       gs0, gs1, irq0, irq1;
    logic [7:0] p0, p1;

    int checks;
    int failures;

    // Reference model state, index 0 = edge mode, 1 = level mode
    logic [7:0] mh     [2][SS+1];
    logic [7:0] m_pend [2];
    logic [2:0] m_a    [2];
    logic       m_ngs  [2];
    logic       m_irq  [2];
    logic       m_inack[2];

    irq_priority_encoder #(.SYNC_STAGES(SS), .EDGE_MODE(1'b1)) u_edge (
        .clk(clk), .n_reset(n_reset), .cen(cen), .n_req(n_req), .n_ei(n_ei), .n_iack(n_iack),
        .a(a0), .n_gs(gs0), .n_irq(irq0), .pending(p0)
    );

    irq_priority_encoder #(.SYNC_STAGES(SS), .EDGE_MODE(1'b0)) u_level (
        .clk(clk), .n_reset(n_reset), .cen(cen), .n_req(n_req), .n_ei(n_ei), .n_iack(n_iack),
        .a(a1), .n_gs(gs1), .n_irq(irq1), .pending(p1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int s = 0; s <= SS; s++) mh[m][s] = 8'hFF;
            m_pend[m]  = 8'h00;
            m_a[m]     = 3'b111;
            m_ngs[m]   = 1'b1;
            m_irq[m]   = 1'b1;
            m_inack[m] = 1'b0;
        end
    endtask

    // One enabled clock of the behavioural model, using pre-edge state.
    task automatic model_step(input int m);
        logic [7:0] rs, prv, np;
        logic [2:0] ai, idx;
        bit ack, found;
        if (!cen) return;
        rs  = mh[m][SS-1];
        prv = mh[m][SS];
        ack = !m_inack[m] && !n_iack && !m_ngs[m];
        if (m == 0) begin
            np = m_pend[m];
            if (ack) begin
                ai = ~m_a[m];
                np[ai] = 1'b0;
            end
            for (int i = 0; i < 8; i++) if (prv[i] && !rs[i]) np[i] = 1'b1;
        end else begin
            np = ~rs;
        end
        if (m_inack[m]) begin
            if (n_iack) begin
                m_inack[m] = 1'b0;
                m_a[m] = 3'b111; m_ngs[m] = 1'b1; m_irq[m] = 1'b1;
            end
        end else if (ack) begin
            m_inack[m] = 1'b1;
            m_irq[m]   = 1'b1;
        end else begin
            found = 1'b0;
            idx   = 3'd0;
            for (int i = 7; i >= 0; i--) begin
                if (!found && m_pend[m][i]) begin
                    found = 1'b1;
                    idx   = 3'(i);
                end
            end
            if (found && !n_ei) begin
                m_a[m] = ~idx; m_ngs[m] = 1'b0; m_irq[m] = 1'b0;
            end else begin
                m_a[m] = 3'b111; m_ngs[m] = 1'b1; m_irq[m] = 1'b1;
            end
        end
        m_pend[m] = np;
        for (int s = SS; s > 0; s--) mh[m][s] = mh[m][s-1];
        mh[m][0] = n_req;
    endtask

    task automatic tick();
        @(posedge clk);
        if (n_reset) begin
            model_step(0);
            model_step(1);
        end
        @(negedge clk);
        chk("edge_a",     a0,   m_a[0]);
        chk("edge_n_gs",  gs0,  m_ngs[0]);
        chk("edge_n_irq", irq0, m_irq[0]);
        chk("edge_pend",  p0,   m_pend[0]);
        chk("lvl_a",      a1,   m_a[1]);
        chk("lvl_n_gs",   gs1,  m_ngs[1]);
        chk("lvl_n_irq",  irq1, m_irq[1]);
        chk("lvl_pend",   p1,   m_pend[1]);
    endtask

    logic [2:0] pr_a [3];
    logic [7:0] pr_p [3];
    logic [7:0] flip;

    initial begin
        checks = 0; failures = 0;
        n_reset = 1'b0; cen = 1'b1; n_req = 8'hFF; n_ei = 1'b0; n_iack = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_a",     a0,   3'b111);
        chk("rst_n_gs",  gs0,  1'b1);
        chk("rst_n_irq", irq0, 1'b1);
        chk("rst_pend",  p0,   8'h00);
        n_reset = 1'b1;
        tick();

        // Single request on bit 3, three-cycle pulse
        n_req = 8'hF7;
        repeat (3) tick();
        chk("single_early_n_irq", irq0, 1'b1);
        n_req = 8'hFF;
        tick();
        chk("single_a",     a0,   3'b100);
        chk("single_n_gs",  gs0,  1'b0);
        chk("single_n_irq", irq0, 1'b0);
        chk("single_pend",  p0,   8'h08);
        n_iack = 1'b0; tick();
        chk("single_ack_n_irq", irq0, 1'b1);
        chk("single_ack_pend",  p0,   8'h00);
        n_iack = 1'b1; tick(); tick();
        chk("single_idle_a", a0, 3'b111);

        // Priority ordering of bits 6, 5, 1
        pr_a[0] = 3'b001; pr_a[1] = 3'b010; pr_a[2] = 3'b110;
        pr_p[0] = 8'h22;  pr_p[1] = 8'h02;  pr_p[2] = 8'h00;
        n_req = ~8'h62;
        repeat (3) tick();
        n_req = 8'hFF;
        repeat (3) tick();
        chk("prio_pend0", p0, 8'h62);
        chk("prio_a0",    a0, 3'b001);
        for (int k = 0; k < 3; k++) begin
            n_iack = 1'b0; tick();
            chk("prio_ack_a",    a0, pr_a[k]);
            chk("prio_ack_pend", p0, pr_p[k]);
            n_iack = 1'b1; tick(); tick();
        end
        chk("prio_done_n_irq", irq0, 1'b1);

        // Set/clear collision on bit 6
        n_req = ~8'h40;
        repeat (3) tick();
        n_req = 8'hFF;
        repeat (3) tick();
        chk("coll_pre_a", a0, 3'b001);
        n_req = ~8'h40;
        tick(); tick();
        n_iack = 1'b0; tick();
        chk("coll_pend",  p0,   8'h40);
        chk("coll_n_irq", irq0, 1'b1);
        n_req = 8'hFF;
        n_iack = 1'b1; tick();
        chk("coll_rel_n_irq", irq0, 1'b1);
        tick();
        chk("coll_reassert_n_irq", irq0, 1'b0);
        chk("coll_reassert_a",     a0,   3'b001);
        n_iack = 1'b0; tick();
        n_iack = 1'b1; tick(); tick();

        // Masking with n_ei, then level-mode re-presentation
        n_ei = 1'b1;
        n_req = ~8'h04;
        repeat (5) tick();
        chk("mask_lvl_a",     a1,   3'b111);
        chk("mask_lvl_n_gs",  gs1,  1'b1);
        chk("mask_lvl_n_irq", irq1, 1'b1);
        chk("mask_lvl_pend",  p1,   8'h04);
        chk("mask_edge_pend", p0,   8'h04);
        n_ei = 1'b0; tick();
        chk("unmask_lvl_a", a1, 3'b101);
        n_iack = 1'b0; tick();
        chk("lvl_ack_n_irq", irq1, 1'b1);
        n_iack = 1'b1; tick(); tick();
        chk("lvl_repr_a",     a1,   3'b101);
        chk("lvl_repr_n_irq", irq1, 1'b0);
        n_req = 8'hFF;
        repeat (4) tick();

        // Clock-enable stall of five cycles inside the sync chain
        n_req = ~8'h10;
        tick();
        cen = 1'b0;
        repeat (5) tick();
        cen = 1'b1;
        repeat (2) tick();
        chk("cen_early_n_irq", irq0, 1'b1);
        tick();
        chk("cen_a",    a0, 3'b011);
        chk("cen_pend", p0, 8'h10);

        // Asynchronous reset in the middle of an acknowledge
        n_iack = 1'b0; tick();
        chk("rack_in_ack", irq0, 1'b1);
        n_reset = 1'b0;
        #1;
        chk("rack_a",     a0,   3'b111);
        chk("rack_n_gs",  gs0,  1'b1);
        chk("rack_n_irq", irq0, 1'b1);
        chk("rack_pend",  p0,   8'h00);
        chk("rack_lvl_pend", p1, 8'h00);
        model_reset();
        n_iack = 1'b1; n_req = 8'hFF;
        #1 n_reset = 1'b1;
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            flip = 8'h00;
            for (int b = 0; b < 8; b++) if ($urandom_range(0, 7) == 0) flip[b] = 1'b1;
            n_req  = n_req ^ flip;
            n_ei   = ($urandom_range(0, 9) == 0);
            cen    = ($urandom_range(0, 9) != 0);
            n_iack = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
